// File: rtl/register_file_p.sv
// Multi-port register file with per-register busy (scoreboard) bits,
// optional zero register, write-to-read bypass and registered reads.
module register_file_p #(
  parameter int WIDTH    = 72,
  parameter int ADDR_W   = 7,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] reg_r_address,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] reg1_address,
  input  logic [ADDR_W-1:0] reg2_address,
  output logic [WIDTH-1:0]  reg1_data,
  output logic [WIDTH-1:0]  reg2_data,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_address,
  input  logic              flush,
  output logic              reg1_busy,
  output logic              reg2_busy,
  output logic              hazard
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic             wr_en;
  logic             rsv_en;
  logic [WIDTH:0]   p1;
  logic [WIDTH:0]   p2;

  assign wr_en  = write &&
                  !(ZERO_REG && reg_r_address == '0);
  assign rsv_en = reserve &&
                  !(ZERO_REG && reserve_address == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[reg_r_address] <= write_data;
    end
  end

  // Set after clear: a new reservation supersedes a retiring producer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (write) begin
        busy_q[reg_r_address] <= 1'b0;
      end
      if (rsv_en) begin
        busy_q[reserve_address] <= 1'b1;
      end
    end
  end

  // Returns {busy, data} for one read address.
  function automatic logic [WIDTH:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic hit;
    hit = BYPASS && wr_en && (a == reg_r_address);
    if (ZERO_REG && a == '0) begin
      rd = '0;
    end else if (hit) begin
      rd = {rsv_en && (reserve_address == a),
            write_data};
    end else begin
      rd = {busy_q[a], mem[a]};
    end
  endfunction

  assign p1 = rd(reg1_address);
  assign p2 = rd(reg2_address);

  if (READ_REG) begin : g_reg
    logic [WIDTH:0] q1;
    logic [WIDTH:0] q2;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q1 <= '0;
        q2 <= '0;
      end else begin
        q1 <= p1;
        q2 <= p2;
      end
    end

    assign {reg1_busy, reg1_data} = q1;
    assign {reg2_busy, reg2_data} = q2;
  end else begin : g_comb
    // Gate so a bypassed write cannot leak out during reset.
    assign {reg1_busy, reg1_data} = reset ? p1 : '0;
    assign {reg2_busy, reg2_data} = reset ? p2 : '0;
  end

  assign hazard = reg1_busy | reg2_busy;

endmodule
